// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control sequencer: state enum,
// datapath mux selects, ALU operations and the opcodes the sequencer decodes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_ADR,
        S_JALR,
        S_TRAP
    } state_t;

    // How the ALU decoder should interpret funct3/funct7_5 in the current state
    typedef enum logic [1:0] {
        AC_ADD,
        AC_SUB,
        AC_R,
        AC_I
    } alu_class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the sequencer (master) and the multicycle datapath
// plus unified memory (slave).
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             Zero;
    logic             mem_ready;
    logic             mem_req;
    logic             MemWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ImmSrc;
    logic [2:0]       ALUControl;
    logic             illegal_insn;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    modport master (
        input  op, funct3, funct7_5, Zero, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_insn,
               cycle_count, instret_count
    );

    modport slave (
        output op, funct3, funct7_5, Zero, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_insn,
               cycle_count, instret_count
    );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation decode from the sequencer's ALU class and the
// instruction funct fields.
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_control_c
);

    always_comb begin
        alu_control_c = ALU_ADD;
        case (alu_class)
            AC_SUB: alu_control_c = ALU_SUB;
            AC_R, AC_I: begin
                case (funct3)
                    // funct7_5 selects sub only for register-register ops; in I-type it is imm bit
                    3'b000:  alu_control_c = (alu_class == AC_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b100:  alu_control_c = ALU_XOR;
                    3'b110:  alu_control_c = ALU_OR;
                    3'b111:  alu_control_c = ALU_AND;
                    3'b010:  alu_control_c = ALU_SLT;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            default: alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control sequencer: one state per cycle, outputs decoded from
// state. Optional perf counters enabled by defining MC_PERF_CNT_EN.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    mc_control_fsm_if.master  ctrl
);

    state_t     state_q;
    state_t     state_nxt;
    alu_class_t alu_class_c;
    logic [2:0] alu_control_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_nxt;
    end

    // Next state and datapath controls; memory-state strobes wait for mem_ready
    always_comb begin
        state_nxt         = state_q;
        alu_class_c       = AC_ADD;
        ctrl.mem_req      = 1'b0;
        ctrl.MemWrite     = 1'b0;
        ctrl.AdrSrc       = 1'b0;
        ctrl.IRWrite      = 1'b0;
        ctrl.PCWrite      = 1'b0;
        ctrl.RegWrite     = 1'b0;
        ctrl.ResultSrc    = RES_ALUOUT;
        ctrl.ALUSrcA      = SRCA_PC;
        ctrl.ALUSrcB      = SRCB_RS2;
        ctrl.ImmSrc       = IMM_I;
        ctrl.illegal_insn = 1'b0;
        case (state_q)
            S_BOOT: state_nxt = S_FETCH;
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.ALUSrcB   = SRCB_FOUR;
                ctrl.ResultSrc = RES_ALURESULT;
                if (ctrl.mem_ready) begin
                    ctrl.IRWrite = 1'b1;
                    ctrl.PCWrite = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.ALUSrcA = SRCA_OLDPC;
                ctrl.ALUSrcB = SRCB_IMM;
                if (ctrl.op == OP_BRANCH)   ctrl.ImmSrc = IMM_B;
                else if (ctrl.op == OP_JAL) ctrl.ImmSrc = IMM_J;
                case (ctrl.op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR_ADR;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_IMM;
                if (ctrl.op == OP_STORE) begin
                    ctrl.ImmSrc = IMM_S;
                    state_nxt   = S_MEMWRITE;
                end else begin
                    state_nxt   = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.AdrSrc  = 1'b1;
                if (ctrl.mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.ResultSrc = RES_DATA;
                ctrl.RegWrite  = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.mem_req  = 1'b1;
                ctrl.MemWrite = 1'b1;
                ctrl.AdrSrc   = 1'b1;
                if (ctrl.mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                ctrl.ALUSrcA = SRCA_RS1;
                alu_class_c  = AC_R;
                state_nxt    = S_ALUWB;
            end
            S_EXEC_I: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_IMM;
                alu_class_c  = AC_I;
                state_nxt    = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.RegWrite = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.ALUSrcA = SRCA_RS1;
                alu_class_c  = AC_SUB;
                ctrl.PCWrite = (ctrl.funct3 == 3'b000 &&  ctrl.Zero) ||
                               (ctrl.funct3 == 3'b001 && !ctrl.Zero);
                state_nxt    = S_FETCH;
            end
            // JALR shares JAL's link-and-jump cycle; ALUOut already holds rs1+imm
            S_JAL, S_JALR: begin
                ctrl.ALUSrcA = SRCA_OLDPC;
                ctrl.ALUSrcB = SRCB_FOUR;
                ctrl.PCWrite = 1'b1;
                state_nxt    = S_ALUWB;
            end
            S_JALR_ADR: begin
                ctrl.ALUSrcA = SRCA_RS1;
                ctrl.ALUSrcB = SRCB_IMM;
                state_nxt    = S_JALR;
            end
            S_TRAP: ctrl.illegal_insn = 1'b1;
            default: state_nxt = S_BOOT;
        endcase
    end

    mc_alu_decode u_alu_decode (
        .alu_class     (alu_class_c),
        .funct3        (ctrl.funct3),
        .funct7_5      (ctrl.funct7_5),
        .alu_control_c (alu_control_c)
    );

    assign ctrl.ALUControl = alu_control_c;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // Counters freeze in TRAP; FETCH stalls and the BOOT exit do not retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else if (state_q != S_TRAP) begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (state_nxt == S_FETCH && state_q != S_BOOT && state_q != S_FETCH)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign ctrl.cycle_count   = cycle_q;
    assign ctrl.instret_count = instret_q;
`else
    assign ctrl.cycle_count   = CNT_W'(0);
    assign ctrl.instret_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver queues per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_mc_control_fsm;

    localparam int unsigned CNT_W = 32;

    // Packed order: mem_req MemWrite AdrSrc IRWrite PCWrite RegWrite
    //               ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal_insn
    function automatic logic [17:0] mk(input logic mreq, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic ill);
        return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    localparam logic [17:0] E_BOOT    = 18'h0;
    localparam logic [17:0] E_FETCH   = mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2'd2,2'd0,2'd2,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_FSTALL  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd2,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_DEC_I   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_DEC_B   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd2,3'd0,1'b0);
    localparam logic [17:0] E_DEC_J   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1,2'd3,3'd0,1'b0);
    localparam logic [17:0] E_EXR_ADD = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_EXR_SUB = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd0,3'd1,1'b0);
    localparam logic [17:0] E_EXR_SLT = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd0,3'd5,1'b0);
    localparam logic [17:0] E_EXI_ADD = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_EXI_XOR = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd0,3'd4,1'b0);
    localparam logic [17:0] E_ALUWB   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd0,2'd0,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_MADR_L  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_MADR_S  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd1,3'd0,1'b0);
    localparam logic [17:0] E_MRD     = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_MWB     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1,2'd0,2'd0,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_MWR     = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_BR_T    = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd2,2'd0,2'd0,3'd1,1'b0);
    localparam logic [17:0] E_BR_N    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0,2'd0,3'd1,1'b0);
    localparam logic [17:0] E_JAL     = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd1,2'd2,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_JADR    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1,2'd0,3'd0,1'b0);
    localparam logic [17:0] E_TRAP    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0,3'd0,1'b1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    logic [17:0] act;
    assign act = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                  bus.illegal_insn};

    typedef struct {
        string       name;
        logic [17:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, act, e.vec);
            end
        end
    end

    task automatic chk(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Drive one cycle's inputs, queue its expected outputs, advance past the edge
    task automatic cyc(input string name, input logic [17:0] vec,
                       input logic rdy = 1'b1, input logic z = 1'b0);
        bus.mem_ready = rdy;
        bus.Zero      = z;
        exp_q.push_back('{name: name, vec: vec});
        @(posedge clk);
        #1;
    endtask

    task automatic insn(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
    endtask

    int unsigned exp_cyc;
    int unsigned exp_ret;

    initial begin
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
        bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", E_BOOT);
        rst_n = 1'b1;
        cyc("boot", E_BOOT);

        insn(7'b0110011, 3'b000, 1'b0);   // add x2,x1,x2
        cyc("add_fetch", E_FETCH); cyc("add_dec", E_DEC_I);
        cyc("add_exec", E_EXR_ADD); cyc("add_wb", E_ALUWB);

        insn(7'b0110011, 3'b000, 1'b1);   // sub
        cyc("sub_fetch", E_FETCH); cyc("sub_dec", E_DEC_I);
        cyc("sub_exec", E_EXR_SUB); cyc("sub_wb", E_ALUWB);

        insn(7'b0110011, 3'b010, 1'b0);   // slt
        cyc("slt_fetch", E_FETCH); cyc("slt_dec", E_DEC_I);
        cyc("slt_exec", E_EXR_SLT); cyc("slt_wb", E_ALUWB);

        insn(7'b0010011, 3'b000, 1'b1);   // addi with imm bit 10 set: still add
        cyc("addi_fetch", E_FETCH); cyc("addi_dec", E_DEC_I);
        cyc("addi_exec", E_EXI_ADD); cyc("addi_wb", E_ALUWB);

        insn(7'b0010011, 3'b100, 1'b0);   // xori
        cyc("xori_fetch", E_FETCH); cyc("xori_dec", E_DEC_I);
        cyc("xori_exec", E_EXI_XOR); cyc("xori_wb", E_ALUWB);

        insn(7'b0000011, 3'b010, 1'b0);   // lw, 3 wait cycles
        cyc("lw_fetch", E_FETCH); cyc("lw_dec", E_DEC_I); cyc("lw_adr", E_MADR_L);
        cyc("lw_wait0", E_MRD, 1'b0); cyc("lw_wait1", E_MRD, 1'b0);
        cyc("lw_wait2", E_MRD, 1'b0); cyc("lw_read", E_MRD, 1'b1);
        cyc("lw_wb", E_MWB);

        insn(7'b0100011, 3'b010, 1'b0);   // sw, fetch and store stalls
        cyc("sw_fstall0", E_FSTALL, 1'b0); cyc("sw_fstall1", E_FSTALL, 1'b0);
        cyc("sw_fetch", E_FETCH); cyc("sw_dec", E_DEC_I); cyc("sw_adr", E_MADR_S);
        cyc("sw_wait", E_MWR, 1'b0); cyc("sw_write", E_MWR, 1'b1);

        insn(7'b1100011, 3'b001, 1'b0);   // bne, Zero=0: taken
        cyc("bne_fetch", E_FETCH); cyc("bne_dec", E_DEC_B); cyc("bne_nz", E_BR_T, 1'b1, 1'b0);
        insn(7'b1100011, 3'b000, 1'b0);   // beq, Zero=0: not taken
        cyc("beq_fetch", E_FETCH); cyc("beq_dec", E_DEC_B); cyc("beq_nz", E_BR_N, 1'b1, 1'b0);
        cyc("beq2_fetch", E_FETCH); cyc("beq2_dec", E_DEC_B); cyc("beq_z", E_BR_T, 1'b1, 1'b1);
        insn(7'b1100011, 3'b001, 1'b0);   // bne, Zero=1: not taken
        cyc("bne2_fetch", E_FETCH); cyc("bne2_dec", E_DEC_B); cyc("bne_z", E_BR_N, 1'b1, 1'b1);
        insn(7'b1100011, 3'b100, 1'b0);   // blt: unsupported condition never taken
        cyc("blt_fetch", E_FETCH); cyc("blt_dec", E_DEC_B); cyc("blt_nz", E_BR_N, 1'b1, 1'b0);

        insn(7'b1101111, 3'b000, 1'b0);   // jal
        cyc("jal_fetch", E_FETCH); cyc("jal_dec", E_DEC_J);
        cyc("jal_jump", E_JAL); cyc("jal_wb", E_ALUWB);

        insn(7'b1100111, 3'b000, 1'b0);   // jalr
        cyc("jalr_fetch", E_FETCH); cyc("jalr_dec", E_DEC_I); cyc("jalr_adr", E_JADR);
        cyc("jalr_jump", E_JAL); cyc("jalr_wb", E_ALUWB);

        insn(7'h7F, 3'b000, 1'b0);        // illegal opcode
        cyc("ill_fetch", E_FETCH); cyc("ill_dec", E_DEC_I);
        cyc("trap0", E_TRAP); cyc("trap1", E_TRAP, 1'b0); cyc("trap2", E_TRAP, 1'b1);

        // Async reset out of TRAP clears illegal_insn immediately
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("trap_async_rst", CNT_W'(act), CNT_W'(E_BOOT));
        @(posedge clk);
        #1;
        cyc("rst_hold", E_BOOT);
        rst_n = 1'b1;
        cyc("boot2", E_BOOT);

        // Reset asserted while FETCH is stalled: mem_req drops at once
        cyc("fetch_stall", E_FSTALL, 1'b0);
        @(negedge clk);
        #2;
        chk("stall_req_before", CNT_W'(bus.mem_req), CNT_W'(1));
        rst_n = 1'b0;
        #1;
        chk("stall_async_rst", CNT_W'(act), CNT_W'(E_BOOT));
        @(posedge clk);
        #1;
        cyc("rst_hold2", E_BOOT);

        // Counter behaviour after a fresh reset
        rst_n = 1'b1;
        cyc("boot3", E_BOOT);
        cyc("fs_a", E_FSTALL, 1'b0); cyc("fs_b", E_FSTALL, 1'b0);
`ifdef MC_PERF_CNT_EN
        exp_cyc = 3; exp_ret = 0;
`else
        exp_cyc = 0; exp_ret = 0;
`endif
        chk("cycle_count_a", bus.cycle_count, CNT_W'(exp_cyc));
        chk("instret_count_a", bus.instret_count, CNT_W'(exp_ret));
        insn(7'b0110011, 3'b000, 1'b0);
        cyc("cnt_fetch", E_FETCH); cyc("cnt_dec", E_DEC_I);
        cyc("cnt_exec", E_EXR_ADD); cyc("cnt_wb", E_ALUWB);
`ifdef MC_PERF_CNT_EN
        exp_cyc = 7; exp_ret = 1;
`endif
        chk("cycle_count_b", bus.cycle_count, CNT_W'(exp_cyc));
        chk("instret_count_b", bus.instret_count, CNT_W'(exp_ret));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
